// File: rtl/mci_arbiter_if.sv
// Bundle of the requester and memory-side ports of mci_arbiter. The struct types mirror
// mci_request_t / mci_response_t of memory_controller_interface.
interface mci_arbiter_if;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mci_request_t;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mci_response_t;

    mci_request_t  ifetch_req;
    mci_response_t ifetch_res;
    mci_request_t  dmem_req;
    mci_response_t dmem_res;
    mci_request_t  mem_req;
    mci_response_t mem_res;

    // The arbiter masters the shared memory port and serves both requesters.
    modport master (
        input  ifetch_req, dmem_req, mem_res,
        output ifetch_res, dmem_res, mem_req
    );

    modport slave (
        output ifetch_req, dmem_req, mem_res,
        input  ifetch_res, dmem_res, mem_req
    );
endinterface

// File: rtl/mci_arbiter.sv
// Two-requester (ifetch/dmem) arbiter serialising 128-bit transactions onto one memory port.
// Define MCI_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise dmem wins every tie.
module mci_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mci_arbiter_if.master bus,
    output logic          o_timeout
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic        GntIfetch = 1'b0;
    localparam logic        GntDmem   = 1'b1;
    localparam bit          WdEn      = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WdLast    = 16'(TIMEOUT_CYCLES - 1);

    state_e       state_q, state_d;
    logic         grant_q, grant_d;
    logic [31:0]  addr_q, addr_d;
    logic [127:0] wdata_q, wdata_d;
    logic         rw_q, rw_d;
    logic [127:0] rdata_q, rdata_d;
    logic [15:0]  wd_q, wd_d;
    logic         timeout_q, timeout_d;
    logic         pick;

    always_comb begin
        if (bus.ifetch_req.valid && bus.dmem_req.valid) begin
`ifdef MCI_ARB_ROUND_ROBIN_EN
            // grant_q resets to dmem, so the first tie goes to ifetch
            pick = ~grant_q;
`else
            pick = GntDmem;
`endif
        end else begin
            pick = bus.dmem_req.valid ? GntDmem : GntIfetch;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        wd_d      = wd_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.ifetch_req.valid || bus.dmem_req.valid) begin
                    grant_d = pick;
                    if (pick == GntDmem) begin
                        addr_d  = bus.dmem_req.addr;
                        wdata_d = bus.dmem_req.data;
                        rw_d    = bus.dmem_req.rw;
                    end else begin
                        addr_d  = bus.ifetch_req.addr;
                        wdata_d = bus.ifetch_req.data;
                        rw_d    = bus.ifetch_req.rw;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                wd_d = wd_q + 16'd1;
                if (bus.mem_res.ready) begin
                    rdata_d = bus.mem_res.data;
                    state_d = StResp;
                end else if (WdEn && (wd_q == WdLast)) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            grant_q   <= GntDmem;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.mem_req.addr  = addr_q;
    assign bus.mem_req.data  = wdata_q;
    assign bus.mem_req.rw    = rw_q;
    assign bus.mem_req.valid = (state_q == StIssue);

    // Both requesters see the latched data; only the granted one gets ready.
    assign bus.ifetch_res.data  = rdata_q;
    assign bus.ifetch_res.ready = (state_q == StResp) && (grant_q == GntIfetch);
    assign bus.dmem_res.data    = rdata_q;
    assign bus.dmem_res.ready   = (state_q == StResp) && (grant_q == GntDmem);

    assign o_timeout = timeout_q;
endmodule

// File: tb/tb_mci_arbiter.sv
// Directed bench for mci_arbiter: reads, writes, tie arbitration, watchdog expiry,
// reset during WAIT and a stray memory ready.
module tb_mci_arbiter;
    localparam int unsigned  TimeoutCycles = 8;
    localparam logic [127:0] Blk0     = 128'h00d00193_00200113_00300093_00000013;
    localparam logic [127:0] WrVal    = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [127:0] StrayVal = 128'h5A5A5A5A_A5A5A5A5_12345678_9ABCDEF0;

    logic clk = 1'b0;
    logic rst;
    logic timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int n_issue = 0;
    int n_if_rdy = 0;
    int n_d_rdy = 0;
    int n_to = 0;
    logic to_with_rdy = 1'b0;

    mci_arbiter_if bus ();

    mci_arbiter #(
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // Memory model: ready appears mem_lat cycles after the issue cycle.
    logic [127:0] mem_q [256];
    int unsigned  mem_lat = 1;
    int unsigned  mem_cnt = 0;
    logic [7:0]   mem_idx = '0;
    bit           mem_mute = 1'b0;
    bit           mem_init = 1'b0;
    bit           stray_ready = 1'b0;

    always @(posedge clk) begin
        if (mem_init) mem_q[0] <= Blk0;
        if (bus.mem_req.valid && !mem_mute) begin
            mem_cnt <= mem_lat;
            mem_idx <= bus.mem_req.addr[11:4];
            if (bus.mem_req.rw) mem_q[bus.mem_req.addr[11:4]] <= bus.mem_req.data;
        end else if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    assign bus.mem_res.data  = stray_ready ? StrayVal : mem_q[mem_idx];
    assign bus.mem_res.ready = (mem_cnt == 1) || stray_ready;

    always @(negedge clk) begin
        if (bus.mem_req.valid) n_issue <= n_issue + 1;
        if (bus.ifetch_res.ready) n_if_rdy <= n_if_rdy + 1;
        if (bus.dmem_res.ready) n_d_rdy <= n_d_rdy + 1;
        if (timeout) begin
            n_to        <= n_to + 1;
            to_with_rdy <= bus.ifetch_res.ready;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit is_d, input bit v, input logic [31:0] a,
                         input logic [127:0] d, input bit rw);
        if (is_d) begin
            bus.dmem_req.addr = a; bus.dmem_req.data = d;
            bus.dmem_req.rw = rw;  bus.dmem_req.valid = v;
        end else begin
            bus.ifetch_req.addr = a; bus.ifetch_req.data = d;
            bus.ifetch_req.rw = rw;  bus.ifetch_req.valid = v;
        end
    endtask

    // Called in an IDLE cycle at negedge; returns in the following IDLE cycle.
    task automatic xact(input string tag, input bit is_d, input logic [31:0] a,
                        input logic [127:0] d, input bit rw,
                        output logic [127:0] rdata, output int cycles);
        drive(is_d, 1'b1, a, d, rw);
        cycles = 0;
        rdata  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (is_d ? bus.dmem_res.ready : bus.ifetch_res.ready) begin
                cycles = i;
                rdata  = is_d ? bus.dmem_res.data : bus.ifetch_res.data;
                check_eq({tag, "_addr_hold"}, 256'(bus.mem_req.addr), 256'(a));
                break;
            end
        end
        drive(is_d, 1'b0, '0, '0, 1'b0);
        check_eq({tag, "_ready_seen"}, 256'(cycles != 0), 256'(1));
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] rd;
        int cyc;
        int b_issue, b_if, b_d, b_to;
        int order[$];
        int exp_order[4];

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        mem_init = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", 256'(bus.mem_req), 256'(0));
        check_eq("rst_res", 256'({bus.ifetch_res, bus.dmem_res}), 256'(0));
        check_eq("rst_timeout", 256'(timeout), 256'(0));
        mem_init = 1'b0;
        rst = 1'b0;

        // Fetch read, memory latency 1: total latency 3
        b_issue = n_issue; b_if = n_if_rdy; b_d = n_d_rdy;
        xact("fetch", 1'b0, 32'h0, '0, 1'b0, rd, cyc);
        check_eq("fetch_data", 256'(rd), 256'(Blk0));
        check_eq("fetch_latency", 256'(cyc), 256'(3));
        check_eq("fetch_issues", 256'(n_issue - b_issue), 256'(1));
        check_eq("fetch_if_rdy", 256'(n_if_rdy - b_if), 256'(1));
        check_eq("fetch_no_d_rdy", 256'(n_d_rdy - b_d), 256'(0));

        // Write then read back, memory latency 2
        mem_lat = 2;
        b_issue = n_issue; b_d = n_d_rdy;
        xact("wr", 1'b1, 32'h100, WrVal, 1'b1, rd, cyc);
        check_eq("wr_latency", 256'(cyc), 256'(4));
        xact("rd", 1'b1, 32'h100, '0, 1'b0, rd, cyc);
        check_eq("rd_data", 256'(rd), 256'(WrVal));
        check_eq("wr_rd_issues", 256'(n_issue - b_issue), 256'(2));
        check_eq("wr_rd_d_rdy", 256'(n_d_rdy - b_d), 256'(2));

        // Stray memory ready in IDLE
        mem_lat = 1;
        b_issue = n_issue; b_if = n_if_rdy; b_d = n_d_rdy;
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        @(negedge clk);
        check_eq("stray_no_rdy", 256'((n_if_rdy - b_if) + (n_d_rdy - b_d)), 256'(0));
        check_eq("stray_no_issue", 256'(n_issue - b_issue), 256'(0));
        check_eq("stray_data_kept", 256'(bus.ifetch_res.data), 256'(WrVal));
        xact("after_stray", 1'b0, 32'h0, '0, 1'b0, rd, cyc);
        check_eq("after_stray_latency", 256'(cyc), 256'(3));
        check_eq("after_stray_data", 256'(rd), 256'(Blk0));

        // Simultaneous requests from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef MCI_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        drive(1'b0, 1'b1, 32'h0, '0, 1'b0);
        drive(1'b1, 1'b1, 32'h100, '0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ifetch_res.ready) order.push_back(0);
            if (bus.dmem_res.ready) order.push_back(1);
            if (order.size() >= 4) break;
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check_eq("tie_count", 256'(order.size()), 256'(4));
        for (int i = 0; i < order.size() && i < 4; i++)
            check_eq($sformatf("tie_grant_%0d", i), 256'(order[i]), 256'(exp_order[i]));

        // Watchdog: memory never answers
        mem_mute = 1'b1;
        b_to = n_to;
        xact("timeout", 1'b0, 32'h40, '0, 1'b0, rd, cyc);
        check_eq("timeout_data", 256'(rd), 256'(0));
        check_eq("timeout_latency", 256'(cyc), 256'(10));
        check_eq("timeout_pulses", 256'(n_to - b_to), 256'(1));
        check_eq("timeout_with_ready", 256'(to_with_rdy), 256'(1));
        mem_mute = 1'b0;
        xact("after_timeout", 1'b1, 32'h100, '0, 1'b0, rd, cyc);
        check_eq("after_timeout_data", 256'(rd), 256'(WrVal));
        check_eq("after_timeout_latency", 256'(cyc), 256'(3));

        // Reset while waiting, then a late memory ready
        mem_lat = 4;
        b_issue = n_issue; b_if = n_if_rdy; b_d = n_d_rdy; b_to = n_to;
        drive(1'b0, 1'b1, 32'h0, '0, 1'b0);
        @(negedge clk);
        check_eq("rstw_issue_pulse", 256'(bus.mem_req.valid), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rstw_no_rdy", 256'((n_if_rdy - b_if) + (n_d_rdy - b_d)), 256'(0));
        check_eq("rstw_no_timeout", 256'(n_to - b_to), 256'(0));
        check_eq("rstw_one_issue", 256'(n_issue - b_issue), 256'(1));
        check_eq("rstw_outputs_zero",
                 256'({bus.mem_req, bus.ifetch_res, bus.dmem_res, timeout}), 256'(0));
        mem_lat = 1;
        xact("post_rst", 1'b0, 32'h0, '0, 1'b0, rd, cyc);
        check_eq("post_rst_data", 256'(rd), 256'(Blk0));
        check_eq("post_rst_latency", 256'(cyc), 256'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
